// File: rtl/lfsr_period_checker_if.sv
// Bundles the LFSR sample stream, the start request and the measurement results.
// The master drives samples and start; the slave is the period checker.
interface lfsr_period_checker_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = WIDTH + 1
);
   logic             start;
   logic [WIDTH-1:0] lfsr_state;
   logic             lfsr_valid;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] period;
   logic             maximal;
   logic             no_repeat;
   logic             zero_seed;

   modport master (
      output start, lfsr_state, lfsr_valid,
      input  busy, done, period, maximal, no_repeat, zero_seed
   );

   modport slave (
      input  start, lfsr_state, lfsr_valid,
      output busy, done, period, maximal, no_repeat, zero_seed
   );
endinterface

// File: rtl/lfsr_period_checker.sv
// Measures the recurrence period of an LFSR output stream: the first valid sample after
// start becomes the reference, and further valid samples are counted until it recurs.
module lfsr_period_checker #(
   parameter int WIDTH = 16,
   parameter int CNT_W = WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   lfsr_period_checker_if.slave  bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_ONE << WIDTH;
   localparam logic [CNT_W-1:0] CNT_MAXLEN = CNT_LIMIT - CNT_ONE;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             maximal_q, maximal_d;
   logic             no_repeat_q, no_repeat_d;
   logic             zero_seed_q, zero_seed_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_next_s;

   // Next-state and result computation for the measurement FSM.
   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      count_d     = count_q;
      period_d    = period_q;
      maximal_d   = maximal_q;
      no_repeat_d = no_repeat_q;
      zero_seed_d = zero_seed_q;
      cnt_next_s  = count_q + CNT_ONE;

      case (state_q)
         S_IDLE, S_DONE: begin
            // A valid sample coinciding with start is deliberately not captured.
            if (bus.start) begin
               state_d     = S_ARM;
               period_d    = {CNT_W{1'b0}};
               maximal_d   = 1'b0;
               no_repeat_d = 1'b0;
               zero_seed_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_ARM: begin
            if (bus.lfsr_valid) begin
               ref_d       = bus.lfsr_state;
               count_d     = {CNT_W{1'b0}};
               zero_seed_d = (bus.lfsr_state == {WIDTH{1'b0}});
               state_d     = S_RUN;
            end else begin
               state_d = S_ARM;
            end
         end
         S_RUN: begin
            // A match on the limiting sample wins, so a 2^WIDTH period is still reported.
            if (!bus.lfsr_valid) begin
               state_d = S_RUN;
            end else if (bus.lfsr_state == ref_q) begin
               period_d  = cnt_next_s;
               maximal_d = (cnt_next_s == CNT_MAXLEN);
               state_d   = S_DONE;
            end else if (cnt_next_s == CNT_LIMIT) begin
               no_repeat_d = 1'b1;
               period_d    = {CNT_W{1'b0}};
               state_d     = S_DONE;
            end else begin
               count_d = cnt_next_s;
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_ARM) || (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ref_q       <= {WIDTH{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         period_q    <= {CNT_W{1'b0}};
         maximal_q   <= 1'b0;
         no_repeat_q <= 1'b0;
         zero_seed_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         count_q     <= count_d;
         period_q    <= period_d;
         maximal_q   <= maximal_d;
         no_repeat_q <= no_repeat_d;
         zero_seed_q <= zero_seed_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.period    = period_q;
   assign bus.maximal   = maximal_q;
   assign bus.no_repeat = no_repeat_q;
   assign bus.zero_seed = zero_seed_q;
endmodule

// File: tb/tb_lfsr_period_checker.sv
// Scoreboard bench for lfsr_period_checker: a 4-bit instance for the small scenarios
// and a default 16-bit instance for the full maximal-length sequence.
module tb_lfsr_period_checker;
   localparam int MODE_LFSR  = 0;
   localparam int MODE_ZERO  = 1;
   localparam int MODE_CNT   = 2;
   localparam int MODE_NOREP = 3;

   typedef struct {
      int period;
      bit maximal;
      bit no_repeat;
      bit zero_seed;
      int fed;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_pass = 0;
   int   n_checks = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   lfsr_period_checker_if #(.WIDTH(4),  .CNT_W(5))  bus4 ();
   lfsr_period_checker_if #(.WIDTH(16), .CNT_W(17)) bus16 ();

   lfsr_period_checker #(.WIDTH(4), .CNT_W(5)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.slave)
   );
   lfsr_period_checker #(.WIDTH(16), .CNT_W(17)) dut16 (
      .clk(clk), .reset(reset), .bus(bus16.slave)
   );

   function automatic logic [3:0] gen4(input int mode, input logic [3:0] cur);
      case (mode)
         MODE_LFSR:  return {cur[2:0], cur[3] ^ cur[2]};
         MODE_ZERO:  return 4'h0;
         MODE_CNT:   return cur + 4'h1;
         MODE_NOREP: return (cur == 4'h4) ? 4'h6 : cur + 4'h1;
         default:    return cur;
      endcase
   endfunction

   // Start from IDLE/DONE with a decoy valid sample, then feed the stream until done.
   task automatic drive4(input int mode, input logic [3:0] seed, input int every,
                         input int phase, input int start_at,
                         output bit done_seen, output int fed);
      logic [3:0] cur;
      bit v;
      cur = seed;
      fed = 0;
      done_seen = 1'b0;
      bus4.start = 1'b1;
      bus4.lfsr_valid = 1'b1;
      bus4.lfsr_state = ~seed;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
         v = (((cyc + phase) % every) == 0);
         bus4.lfsr_valid = v;
         bus4.lfsr_state = v ? cur : 4'($urandom_range(0, 15));
         bus4.start = (cyc == start_at);
         @(posedge clk); #1;
         if (v) begin
            fed++;
            cur = gen4(mode, cur);
         end
         done_seen = bus4.done;
      end
      bus4.start = 1'b0;
      bus4.lfsr_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if ({bus4.busy, bus4.done, bus4.period, bus4.maximal, bus4.no_repeat, bus4.zero_seed} !== 10'd0)
         $display("FAIL reset4 outputs got %b want 0", {bus4.busy, bus4.done, bus4.period, bus4.maximal, bus4.no_repeat, bus4.zero_seed}); else n_pass++;
      n_checks++; if ({bus16.busy, bus16.done, bus16.period, bus16.maximal, bus16.no_repeat, bus16.zero_seed} !== 22'd0)
         $display("FAIL reset16 outputs got %h want 0", {bus16.busy, bus16.done, bus16.period, bus16.maximal, bus16.no_repeat, bus16.zero_seed}); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_lfsr4();
      exp_t e; bit ds; int fed;
      sb_q.push_back('{15, 1'b1, 1'b0, 1'b0, 16});
      drive4(MODE_LFSR, 4'h1, 1, 0, -1, ds, fed);
      e = sb_q.pop_front();
      n_checks++; if (!ds) $display("FAIL lfsr4 done_timeout got 0 want 1"); else n_pass++;
      n_checks++; if (fed !== e.fed) $display("FAIL lfsr4 samples got %0d want %0d", fed, e.fed); else n_pass++;
      n_checks++; if (int'(bus4.period) !== e.period) $display("FAIL lfsr4 period got %0d want %0d", bus4.period, e.period); else n_pass++;
      n_checks++; if ({bus4.maximal, bus4.no_repeat, bus4.zero_seed, bus4.busy} !== {e.maximal, e.no_repeat, e.zero_seed, 1'b0})
         $display("FAIL lfsr4 flags got %b want %b", {bus4.maximal, bus4.no_repeat, bus4.zero_seed, bus4.busy}, {e.maximal, e.no_repeat, e.zero_seed, 1'b0}); else n_pass++;
      // Results must hold in DONE while unrelated samples keep arriving.
      repeat (4) begin
         bus4.lfsr_valid = 1'b1;
         bus4.lfsr_state = 4'($urandom_range(0, 15));
         @(posedge clk); #1;
      end
      bus4.lfsr_valid = 1'b0;
      n_checks++; if ({bus4.done, bus4.period, bus4.maximal} !== {1'b1, 5'd15, 1'b1})
         $display("FAIL lfsr4_hold got %b want %b", {bus4.done, bus4.period, bus4.maximal}, {1'b1, 5'd15, 1'b1}); else n_pass++;
   endtask

   task automatic test_zero();
      exp_t e; bit ds; int fed;
      sb_q.push_back('{1, 1'b0, 1'b0, 1'b1, 2});
      drive4(MODE_ZERO, 4'h0, 1, 0, -1, ds, fed);
      e = sb_q.pop_front();
      n_checks++; if (!ds || fed !== e.fed) $display("FAIL zero samples got %0d (done %0b) want %0d", fed, ds, e.fed); else n_pass++;
      n_checks++; if (int'(bus4.period) !== e.period) $display("FAIL zero period got %0d want %0d", bus4.period, e.period); else n_pass++;
      n_checks++; if ({bus4.maximal, bus4.no_repeat, bus4.zero_seed} !== {e.maximal, e.no_repeat, e.zero_seed})
         $display("FAIL zero flags got %b want %b", {bus4.maximal, bus4.no_repeat, bus4.zero_seed}, {e.maximal, e.no_repeat, e.zero_seed}); else n_pass++;
   endtask

   task automatic test_counter();
      exp_t e; bit ds; int fed;
      sb_q.push_back('{16, 1'b0, 1'b0, 1'b0, 17});
      drive4(MODE_CNT, 4'h3, 1, 0, -1, ds, fed);
      e = sb_q.pop_front();
      n_checks++; if (!ds || fed !== e.fed) $display("FAIL counter samples got %0d (done %0b) want %0d", fed, ds, e.fed); else n_pass++;
      n_checks++; if (int'(bus4.period) !== e.period) $display("FAIL counter period got %0d want %0d", bus4.period, e.period); else n_pass++;
      n_checks++; if ({bus4.maximal, bus4.no_repeat, bus4.zero_seed} !== {e.maximal, e.no_repeat, e.zero_seed})
         $display("FAIL counter flags got %b want %b", {bus4.maximal, bus4.no_repeat, bus4.zero_seed}, {e.maximal, e.no_repeat, e.zero_seed}); else n_pass++;
   endtask

   task automatic test_no_repeat();
      exp_t e; bit ds; int fed;
      sb_q.push_back('{0, 1'b0, 1'b1, 1'b0, 17});
      drive4(MODE_NOREP, 4'h5, 1, 0, -1, ds, fed);
      e = sb_q.pop_front();
      n_checks++; if (!ds || fed !== e.fed) $display("FAIL norep samples got %0d (done %0b) want %0d", fed, ds, e.fed); else n_pass++;
      n_checks++; if (int'(bus4.period) !== e.period) $display("FAIL norep period got %0d want %0d", bus4.period, e.period); else n_pass++;
      n_checks++; if ({bus4.maximal, bus4.no_repeat, bus4.zero_seed} !== {e.maximal, e.no_repeat, e.zero_seed})
         $display("FAIL norep flags got %b want %b", {bus4.maximal, bus4.no_repeat, bus4.zero_seed}, {e.maximal, e.no_repeat, e.zero_seed}); else n_pass++;
   endtask

   task automatic test_sparse_valid();
      exp_t e; bit ds; int fed;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      sb_q.push_back('{15, 1'b1, 1'b0, 1'b0, 16});
      drive4(MODE_LFSR, 4'h9, 3, int'($urandom_range(0, 2)), -1, ds, fed);
      e = sb_q.pop_front();
      n_checks++; if (!ds || fed !== e.fed) $display("FAIL sparse samples got %0d (done %0b) want %0d", fed, ds, e.fed); else n_pass++;
      n_checks++; if ({bus4.period, bus4.maximal, bus4.no_repeat} !== {5'(e.period), e.maximal, e.no_repeat})
         $display("FAIL sparse result got %b want %b", {bus4.period, bus4.maximal, bus4.no_repeat}, {5'(e.period), e.maximal, e.no_repeat}); else n_pass++;
   endtask

   task automatic test_start_ignored();
      exp_t e; bit ds; int fed;
      sb_q.push_back('{15, 1'b1, 1'b0, 1'b0, 16});
      drive4(MODE_LFSR, 4'h1, 1, 0, 5, ds, fed);
      e = sb_q.pop_front();
      n_checks++; if (!ds || fed !== e.fed) $display("FAIL start_in_run samples got %0d (done %0b) want %0d", fed, ds, e.fed); else n_pass++;
      n_checks++; if (int'(bus4.period) !== e.period) $display("FAIL start_in_run period got %0d want %0d", bus4.period, e.period); else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      logic [3:0] cur;
      cur = 4'h1;
      bus4.start = 1'b1;
      @(posedge clk); #1;
      bus4.start = 1'b0;
      // Capture plus seven further samples leaves the counter at 7.
      repeat (8) begin
         bus4.lfsr_valid = 1'b1;
         bus4.lfsr_state = cur;
         @(posedge clk); #1;
         cur = gen4(MODE_LFSR, cur);
      end
      n_checks++; if ({bus4.busy, bus4.done} !== 2'b10) $display("FAIL midrun_busy got %b want 10", {bus4.busy, bus4.done}); else n_pass++;
      bus4.lfsr_state = cur;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_checks++; if ({bus4.busy, bus4.done, bus4.period, bus4.maximal, bus4.no_repeat, bus4.zero_seed} !== 10'd0)
         $display("FAIL midrun_reset got %b want 0", {bus4.busy, bus4.done, bus4.period, bus4.maximal, bus4.no_repeat, bus4.zero_seed}); else n_pass++;
      // Back in IDLE: the rest of the sequence, including the reference, must not complete anything.
      repeat (12) begin
         cur = gen4(MODE_LFSR, cur);
         bus4.lfsr_state = cur;
         @(posedge clk); #1;
      end
      bus4.lfsr_valid = 1'b0;
      n_checks++; if ({bus4.busy, bus4.done} !== 2'b00) $display("FAIL midrun_idle got %b want 00", {bus4.busy, bus4.done}); else n_pass++;
   endtask

   task automatic test_lfsr16();
      exp_t e;
      logic [15:0] s;
      int fed;
      bit ds;
      s = 16'h0676;
      fed = 0;
      ds = 1'b0;
      sb_q.push_back('{65535, 1'b1, 1'b0, 1'b0, 65536});
      bus16.start = 1'b1;
      bus16.lfsr_valid = 1'b1;
      bus16.lfsr_state = ~s;
      @(posedge clk); #1;
      bus16.start = 1'b0;
      for (int cyc = 0; cyc < 70000 && !ds; cyc++) begin
         bus16.lfsr_state = s;
         @(posedge clk); #1;
         fed++;
         s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
         ds = bus16.done;
      end
      bus16.lfsr_valid = 1'b0;
      e = sb_q.pop_front();
      n_checks++; if (!ds || fed !== e.fed) $display("FAIL lfsr16 samples got %0d (done %0b) want %0d", fed, ds, e.fed); else n_pass++;
      n_checks++; if (int'(bus16.period) !== e.period) $display("FAIL lfsr16 period got %0d want %0d", bus16.period, e.period); else n_pass++;
      n_checks++; if ({bus16.maximal, bus16.no_repeat, bus16.zero_seed} !== {e.maximal, e.no_repeat, e.zero_seed})
         $display("FAIL lfsr16 flags got %b want %b", {bus16.maximal, bus16.no_repeat, bus16.zero_seed}, {e.maximal, e.no_repeat, e.zero_seed}); else n_pass++;
   endtask

   initial begin
      bus4.start = 1'b0;
      bus4.lfsr_valid = 1'b0;
      bus4.lfsr_state = 4'h0;
      bus16.start = 1'b0;
      bus16.lfsr_valid = 1'b0;
      bus16.lfsr_state = 16'h0000;
      test_reset();
      test_lfsr4();
      test_zero();
      test_counter();
      test_no_repeat();
      test_sparse_valid();
      test_start_ignored();
      test_reset_mid_run();
      test_lfsr16();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/lfsr_period_checker.md
Name: lfsr_period_checker

Overview:
- Hardware consumer placed directly downstream of the lfsr block. Samples the LFSR's shifted state output on each advance strobe.
- On start, captures the first sample as the reference. It then counts further samples until the reference value recurs and reports the period.
- Flags maximal-length sequences (period = 2^WIDTH - 1), the all-zero lock-up, and sequences that never return to the reference.
- Replaces the manual compare-and-count loop of the LFSR bench with synthesizable logic usable in-system.

Parameters:
- WIDTH, 16, LFSR state width in bits; matches the lfsr shifted-state output.
- CNT_W, WIDTH+1, period/counter width; must hold the value 2^WIDTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a measurement.
- lfsr_state  input  WIDTH  current LFSR output (shifted seed).
- lfsr_valid  input  1  lfsr_state is a new step this cycle.
- busy  output  1  high in ARM or RUN.
- done  output  1  high while in DONE; results are valid.
- period  output  CNT_W  measured period; 0 if no_repeat.
- maximal  output  1  period == 2^WIDTH - 1.
- no_repeat  output  1  no recurrence within 2^WIDTH samples.
- zero_seed  output  1  captured reference was all zeros.

Behaviour:
- Single clock; synchronous active-high reset.
- Reset values: busy=0, done=0, period=0, maximal=0, no_repeat=0, zero_seed=0. Internal ref=0, count=0, state=IDLE.
- Reset has priority over all other inputs, in any state.
- Reset asserted mid-measurement aborts it. All outputs are at their reset values in the cycle after the reset edge.

States:
- IDLE
  - start=1 -> ARM; clear all result outputs.
  - lfsr_valid is ignored.
- ARM
  - Wait for lfsr_valid=1.
  - On that edge: ref <= lfsr_state; count <= 0; zero_seed <= (lfsr_state == 0); go to RUN.
- RUN
  - Each edge with lfsr_valid=1: next = count + 1.
  - If lfsr_state == ref: period <= next; maximal <= (next == 2^WIDTH - 1); go to DONE.
  - Else if next == 2^WIDTH: no_repeat <= 1; period <= 0; go to DONE.
  - Else: count <= next.
  - Cycles with lfsr_valid=0 change nothing.
- DONE
  - Results held stable.
  - start=1 -> clear results, go to ARM.

Latency and timing:
- The match sample is seen at edge k. done, period and maximal are visible in the cycle after edge k and update together.
- start is ignored in ARM and RUN; there is no restart while busy.
- start and lfsr_valid together in IDLE or DONE: that sample is NOT captured. Capture occurs on the first valid in ARM.
- Counter is unsigned, CNT_W bits, and never wraps: it terminates at 2^WIDTH.
- The comparison is an exact WIDTH-bit equality.
- The all-zero reference legitimately yields period=1 with zero_seed=1 (stuck XOR LFSR).
- A period of 2^WIDTH (e.g. a full binary counter source) is reported as a match, not as no_repeat. The match check takes precedence over the limit check on the same edge.

Test Plan:
1. WIDTH=4, Fibonacci LFSR x^4+x^3+1, seed 4'b0001, lfsr_valid=1 every cycle, start pulse -> done after 16 valid samples post-start; period=15, maximal=1, zero_seed=0, no_repeat=0.
2. Default WIDTH=16, maximal 16-bit LFSR (taps 16,14,13,11), seed 16'h0676 -> period=65535, maximal=1.
3. WIDTH=4, lfsr_state held 4'h0 -> zero_seed=1, period=1, maximal=0, done one cycle after the second valid sample.
4. WIDTH=4, free-running counter 0..15 wrapping -> period=16, maximal=0, no_repeat=0. Repeat with first sample 4'h5 followed only by values != 5 -> after 16 samples no_repeat=1, period=0.
5. WIDTH=4 LFSR of case 1, lfsr_valid high 1 cycle in 3, random start offset -> period=15. State and counter frozen on invalid cycles.
6. Reset asserted mid-RUN (count=7) -> next cycle busy=0, done=0, period=0, all flags 0, state IDLE. A start pulse during RUN is ignored and the measurement completes with period=15.
